// File: rtl/mont_red_iter_if.sv
// mont_red_iter_if
// Groups the input and output valid/ready handshakes of the iterative
// Montgomery reducer into one bundle.
//   qH        : high part of the modulus q = qH*2^R + 1
//   C         : product to be reduced
//   in_valid  : C/qH are valid
//   in_ready  : reducer can accept a new operand
//   T         : reduced result C*2^(-R*STEP) mod q
//   out_valid : T is valid
//   out_ready : consumer accepts T
// The master modport is the producer/consumer side; the slave modport is the
// reducer itself.
interface mont_red_iter_if #(
   parameter int K     = 128,
   parameter int Q_LEN = 64,
   parameter int R     = 32
);
   logic [Q_LEN-R-1:0] qH;
   logic [K-1:0]       C;
   logic               in_valid;
   logic               in_ready;
   logic [Q_LEN:0]     T;
   logic               out_valid;
   logic               out_ready;

   modport master (
      output qH, C, in_valid, out_ready,
      input  in_ready, T, out_valid
   );

   modport slave (
      input  qH, C, in_valid, out_ready,
      output in_ready, T, out_valid
   );
endinterface

// File: rtl/mont_red_iter.sv
// mont_red_iter
// Word-serial Montgomery reduction for moduli q = qH*2^R + 1. A single R-bit
// word-reduction step is reused for STEP = (K-Q_LEN)/R cycles, optionally
// followed by one conditional subtraction of q.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of mont_red_iter_if (operand in, result out)
// Latency from the accept edge to out_valid is STEP+FINAL_SUB edges.
module mont_red_iter #(
   parameter int K         = 128,
   parameter int Q_LEN     = 64,
   parameter int R         = 32,
   parameter int FINAL_SUB = 1
) (
   input  logic           clk,
   input  logic           rst_n,
   mont_red_iter_if.slave bus
);
   localparam int STEP = (K - Q_LEN) / R;
   localparam int CW   = $clog2(STEP + 1);

   typedef enum logic [1:0] {IDLE, RED, SUB, DONE} state_t;

   state_t             state_q, state_d;
   logic [K-1:0]       acc_q, acc_d;
   logic [Q_LEN-R-1:0] qh_q, qh_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [Q_LEN:0]     t_q, t_d;

   logic               in_ready_w;
   logic               accept;
   logic [R-1:0]       lo;
   logic [R-1:0]       m;
   logic               carry;
   logic [Q_LEN-1:0]   prod;
   logic [K-1:0]       acc_step;
   logic [Q_LEN:0]     q_ext;
   logic [Q_LEN:0]     sub_res;

   // The output handshake frees the block in the same cycle, so a new
   // operand can be taken while the old result is being consumed.
   assign in_ready_w    = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
   assign accept        = in_ready_w && bus.in_valid;
   assign bus.in_ready  = in_ready_w;
   assign bus.out_valid = (state_q == DONE);
   assign bus.T         = t_q;

   // One word step: choose m so the low word of acc + m*q vanishes. Since
   // q = qh*2^R + 1, (acc + m*q)/2^R = (acc >> R) + m*qh + (lo != 0), the
   // last term being the carry out of lo + m, which is exactly 2^R or 0.
   always_comb begin
      lo       = acc_q[R-1:0];
      m        = '0 - lo;
      carry    = |lo;
      prod     = {{(Q_LEN-R){1'b0}}, m} * {{R{1'b0}}, qh_q};
      acc_step = (acc_q >> R) + K'(prod) + K'(carry);
   end

   // After the last word step acc < 2q, so it fits in Q_LEN+1 bits and a
   // single subtraction fully reduces it.
   always_comb begin
      q_ext   = {1'b0, qh_q, {R{1'b0}}} + (Q_LEN+1)'(1);
      sub_res = (acc_q[Q_LEN:0] >= q_ext) ? (acc_q[Q_LEN:0] - q_ext) : acc_q[Q_LEN:0];
   end

   // Next-state logic. Loading a new operand is handled after the case so
   // that the IDLE accept and the DONE back-to-back accept share one path.
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      qh_d    = qh_q;
      cnt_d   = cnt_q;
      t_d     = t_q;
      case (state_q)
         IDLE: begin
            state_d = IDLE;
         end
         RED: begin
            acc_d = acc_step;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(STEP - 1)) begin
               if (FINAL_SUB != 0) begin
                  state_d = SUB;
               end else begin
                  t_d     = acc_step[Q_LEN:0];
                  state_d = DONE;
               end
            end
         end
         SUB: begin
            t_d     = sub_res;
            state_d = DONE;
         end
         DONE: begin
            if (bus.out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      if (accept) begin
         acc_d   = bus.C;
         qh_d    = bus.qH;
         cnt_d   = '0;
         state_d = RED;
      end
   end

   // State registers; reset aborts any operation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         acc_q   <= '0;
         qh_q    <= '0;
         cnt_q   <= '0;
         t_q     <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         qh_q    <= qh_d;
         cnt_q   <= cnt_d;
         t_q     <= t_d;
      end
   end
endmodule

// File: doc/mont_red_iter.md
# mont_red_iter

Iterative, word-serial Montgomery reduction for moduli of the form q = qH·2^R + 1. The block reuses a single R-bit word-reduction datapath over STEP = (K−Q_LEN)/R cycles instead of unrolling STEP stages, which trades throughput for area. It adds a valid/ready handshake on both sides, a parametrised word width, and an optional final conditional subtraction. It sits between the multiplier product output and the NTT/modmul result consumer.

## Interface
- K, 128: input product width in bits.
- Q_LEN, 64: modulus width in bits.
- R, 32: word width per iteration. Legal values satisfy R < Q_LEN, R divides (K−Q_LEN), and K−Q_LEN ≥ R.
- FINAL_SUB, 1: 1 = output fully reduced to [0, q); 0 = output in [0, 2q).
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- qH  in  Q_LEN−R  high part of q; sampled on input handshake.
- C  in  K  value to reduce; must satisfy C < q·2^(R·STEP).
- in_valid  in  1  C/qH valid.
- in_ready  out  1  block can accept.
- T  out  Q_LEN+1  result C·2^(−R·STEP) mod q; bit Q_LEN is always 0 when FINAL_SUB=1.
- out_valid  out  1  T valid.
- out_ready  in  1  consumer accepts T.

## Operation
- Registers:
  - acc (K bits)
  - qh_r (Q_LEN−R bits)
  - step counter cnt (clog2(STEP+1) bits)
  - T register
  - FSM state
- FSM states:
  - IDLE: in_ready=1. On in_valid, load acc←C and qh_r←qH, set cnt←0, go to RED.
  - RED: each cycle, do one word step and increment cnt. After the STEP-th step, go to SUB if FINAL_SUB=1, otherwise load T←acc and go to DONE.
  - SUB: T ← (acc ≥ q) ? acc−q : acc, where q = {qh_r, R'b0}+1. Go to DONE.
  - DONE: out_valid=1 and T is held stable. On out_ready, go to IDLE.
- Word step:
  - lo = acc[R−1:0]
  - m = (2^R − lo) mod 2^R
  - carry = (lo ≠ 0)
  - acc ← (acc >> R) + m·qh_r + carry
  - This is exactly (acc + m·q)/2^R.
- Widths: the product m·qh_r is Q_LEN bits. The sum never exceeds K bits given the input bound on C; no overflow detection is required.
- Back-to-back: in_ready = (state==IDLE) || (state==DONE && out_ready). If DONE, out_ready and in_valid are all high, the output handshake and the input load happen on the same edge, and the next state is RED.
- in_valid while busy (RED/SUB, or DONE with out_ready=0): ignored. in_ready is 0 in these states, so nothing is loaded.
- Inputs C/qH are don't-care outside the accept cycle.

## Timing
- Reset (rst low, asynchronous):
  - state=IDLE, out_valid=0, T=0, acc=0, qh_r=0, cnt=0.
  - in_ready=1 once in IDLE.
- Reset asserted mid-operation aborts the operation. No out_valid pulse is produced, and the partial result is lost.
- Latency: with the accept edge as edge 0, out_valid rises after edge STEP+FINAL_SUB.
  - Defaults (STEP=2, FINAL_SUB=1): 3 cycles.
  - FINAL_SUB=0: 2 cycles.
- Throughput:
  - With out_ready held high and back-to-back accept, one result per STEP+FINAL_SUB+1 cycles.
  - Defaults: one result per 4 cycles.
- out_valid stays high and T stays stable until out_ready is sampled high. Both deassert/leave DONE on the following edge unless a new input is accepted on the same edge.
- out_valid, in_ready and T do not depend combinationally on in_valid. in_ready does depend combinationally on out_ready in DONE.

## Test plan
All scenarios use the defaults (K=128, Q_LEN=64, R=32) with qH=0xFFFFFFFF, so q=0xFFFFFFFF00000001.

- **Basic reduction:** C=2^64 → T=1, out_valid 3 cycles after the accept edge. C=5·2^64 → T=5. C=0 → T=0.
- **Boundary at q:** C=q.
  - FINAL_SUB=1 → T=0.
  - FINAL_SUB=0 → T=q (0xFFFFFFFF00000001) at 2-cycle latency.
- **Maximum input:** C=q·2^64−1 with FINAL_SUB=1 → T < q and bit 64 = 0. Checked against the reference model (C·2^−64 mod q) for 10k random C below the bound, with random qH giving odd q.
- **Backpressure:** hold out_ready=0 for 5 cycles after out_valid.
  - T is stable, in_ready=0, and in_valid pulses are ignored.
  - Then raise out_ready with in_valid=1: the new input is accepted on the same edge, and the next result follows 3 cycles later.
- **Reset mid-operation:** assert rst low during RED (cnt=1).
  - Outputs go to reset values immediately, with no out_valid.
  - After release, a new C=2^64 gives T=1.
- **Parametrisation:** K=96, Q_LEN=32, R=16, qH=0x7800 (q=0x78000001), C=2^64 → T=1 after 4 STEP + 1 SUB = 5 cycles.
